// File: rtl/wavetable_lerp_seq.sv
// Wavetable sequencer: phase accumulator, two-entry table fetch, hand-off to a
// combinational interpolator and a valid/ready sample register.
// Optional hard-sync phase clear port enabled by defining WTL_PHASE_CLR_EN.
module wavetable_lerp_seq #(
  parameter int WIDTH     = 8,
  parameter int PRECISION = 16,
  parameter int ADDR_W    = 8
) (
  input  logic                               i_clk,
  input  logic                               i_rst_n,
`ifdef WTL_PHASE_CLR_EN
  input  logic                               i_phase_clr,
`endif
  input  logic                               i_enable,
  input  logic [ADDR_W+PRECISION-1:0]        i_step,
  output logic                               o_tbl_rd,
  output logic [ADDR_W-1:0]                  o_tbl_addr,
  input  logic signed [WIDTH-1:0]            i_tbl_data,
  output logic signed [WIDTH-1:0]            o_lerp_low,
  output logic signed [WIDTH-1:0]            o_lerp_high,
  output logic [PRECISION-1:0]               o_lerp_ctrl,
  input  logic signed [WIDTH+PRECISION-1:0]  i_lerp_out,
  output logic signed [WIDTH+PRECISION-1:0]  o_sample,
  output logic                               o_valid,
  input  logic                               i_ready,
  output logic                               o_busy
);

  localparam int PHASE_W = ADDR_W + PRECISION;

  typedef enum logic [2:0] {
    IDLE,
    RD_LO,
    RD_HI,
    WAIT_HI,
    LERP,
    OUT
  } state_t;

  state_t                            state, state_nxt;
  logic [PHASE_W-1:0]                ph;
  logic [ADDR_W-1:0]                 idx;
  logic signed [WIDTH-1:0]           low_q, high_q;
  logic signed [WIDTH+PRECISION-1:0] sample_q;
  logic                              handshake;
  logic                              phase_clr;

`ifdef WTL_PHASE_CLR_EN
  assign phase_clr = i_phase_clr;
`else
  assign phase_clr = 1'b0;
`endif

  assign idx         = ph[PHASE_W-1:PRECISION];
  assign handshake   = (state == OUT) && i_ready;
  assign o_lerp_low  = low_q;
  assign o_lerp_high = high_q;
  assign o_lerp_ctrl = ph[PRECISION-1:0];
  assign o_sample    = sample_q;
  assign o_valid     = (state == OUT);
  assign o_busy      = (state != IDLE);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    o_tbl_rd   = 1'b0;
    o_tbl_addr = '0;
    unique case (state)
      IDLE:    if (i_enable) state_nxt = RD_LO;
      RD_LO: begin
        o_tbl_rd   = 1'b1;
        o_tbl_addr = idx;
        state_nxt  = RD_HI;
      end
      RD_HI: begin
        // ADDR_W-bit add wraps the last entry back to entry 0
        o_tbl_rd   = 1'b1;
        o_tbl_addr = idx + ADDR_W'(1);
        state_nxt  = WAIT_HI;
      end
      WAIT_HI: state_nxt = LERP;
      LERP:    state_nxt = OUT;
      OUT:     if (i_ready) state_nxt = i_enable ? RD_LO : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ph       <= '0;
      low_q    <= '0;
      high_q   <= '0;
      sample_q <= '0;
    end else begin
      if ((state == IDLE) && phase_clr) ph <= '0;
      else if (handshake)               ph <= phase_clr ? '0 : ph + i_step;
      if (state == RD_HI)   low_q    <= i_tbl_data;
      if (state == WAIT_HI) high_q   <= i_tbl_data;
      if (state == LERP)    sample_q <= i_lerp_out;
    end
  end

endmodule

// File: tb/tb_wavetable_lerp_seq.sv
// Scoreboard bench for wavetable_lerp_seq: table RAM and interpolator stubs,
// phase-queue reference model, directed corner cases plus random traffic.
module tb_wavetable_lerp_seq;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               en, rdy, clr;
  logic [23:0]        step;
  logic               tbl_rd;
  logic [7:0]         tbl_addr;
  logic signed [7:0]  tbl_q;
  logic signed [7:0]  lerp_low, lerp_high;
  logic [15:0]        lerp_ctrl;
  logic signed [23:0] lerp_out;
  logic signed [31:0] lerp_full;
  logic signed [23:0] sample;
  logic               valid, busy;

  logic [7:0]  mem [256];
  logic [23:0] ph_q[$];
  logic [23:0] ph_m;
  int          total = 0;
  int          bad   = 0;

  always #5 clk = ~clk;

  wavetable_lerp_seq #(.WIDTH(8), .PRECISION(16), .ADDR_W(8)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
`ifdef WTL_PHASE_CLR_EN
    .i_phase_clr(clr),
`endif
    .i_enable(en), .i_step(step),
    .o_tbl_rd(tbl_rd), .o_tbl_addr(tbl_addr), .i_tbl_data(tbl_q),
    .o_lerp_low(lerp_low), .o_lerp_high(lerp_high), .o_lerp_ctrl(lerp_ctrl),
    .i_lerp_out(lerp_out), .o_sample(sample), .o_valid(valid),
    .i_ready(rdy), .o_busy(busy)
  );

  // Synchronous table RAM with one-cycle read latency
  always @(posedge clk) if (tbl_rd) tbl_q <= mem[tbl_addr];

  // Interpolator written as a weighted sum of both operands
  assign lerp_full = $signed(lerp_low) * (32'sd65536 - $signed({16'd0, lerp_ctrl}))
                   + $signed(lerp_high) * $signed({16'd0, lerp_ctrl});
  assign lerp_out  = lerp_full[23:0];

  function automatic void chk(string nm, int act, int expv);
    total++;
    if (act != expv) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
    end
  endfunction

  function automatic int exp_of(logic [23:0] p);
    logic [7:0] i0, i1;
    int lo, hi, f;
    i0 = p[23:16];
    i1 = i0 + 8'd1;
    lo = int'($signed(mem[i0]));
    hi = int'($signed(mem[i1]));
    f  = int'(p[15:0]);
    return (lo * 65536 + (hi - lo) * f) & 32'h00FF_FFFF;
  endfunction

  // Monitor: each accepted sample pops the phase it must have been computed from
  always @(negedge clk) begin
    if (rst_n) begin
`ifdef WTL_PHASE_CLR_EN
      if (!busy && clr) begin
        ph_m = '0;
        ph_q.delete();
        ph_q.push_back(ph_m);
      end
`endif
      if (valid && rdy) begin
        if (ph_q.size() == 0) begin
          chk("sb_empty", 1, 0);
        end else begin
          logic [23:0] p;
          p = ph_q.pop_front();
          chk("sample", int'(sample) & 32'h00FF_FFFF, exp_of(p));
          chk("lerp_ctrl", int'(lerp_ctrl), int'(p[15:0]));
          chk("lerp_low", int'(lerp_low) & 32'hFF, int'(mem[p[23:16]]));
        end
        ph_m = (clr ? 24'd0 : ph_m + step);
        ph_q.push_back(ph_m);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!valid && n < 40) begin
      tick();
      n++;
    end
    chk("valid_timeout", int'(valid), 1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 60) begin
      tick();
      n++;
    end
    chk("idle_timeout", int'(busy), 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    en    = 1'b0;
    clr   = 1'b0;
    #1;
    chk("rst_valid", int'(valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_rd", int'(tbl_rd), 0);
    chk("rst_addr", int'(tbl_addr), 0);
    chk("rst_sample", int'(sample) & 32'h00FF_FFFF, 0);
    chk("rst_low", int'(lerp_low) & 32'hFF, 0);
    chk("rst_high", int'(lerp_high) & 32'hFF, 0);
    chk("rst_ctrl", int'(lerp_ctrl), 0);
    repeat (2) @(posedge clk);
    ph_m = '0;
    ph_q.delete();
    ph_q.push_back(ph_m);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; en = 1'b0; rdy = 1'b0; clr = 1'b0; step = '0;
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    do_reset();

    // Basic: latency k+4, then 5-cycle cadence
    mem[0] = 8'h10; mem[1] = 8'h20;
    step = 24'h008000; rdy = 1'b1; en = 1'b1;
    tick();
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk("latency", int'(valid), int'(i == 4));
    end
    chk("basic0", int'(sample) & 32'h00FF_FFFF, 32'h100000);
    tick();
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk("throughput", int'(valid), int'(i == 4));
    end
    chk("basic1", int'(sample) & 32'h00FF_FFFF, 32'h180000);
    en = 1'b0;
    wait_idle();

    // Backpressure: everything frozen while OUT waits
    rdy = 1'b0; en = 1'b1;
    wait_valid();
    begin
      int s, c;
      s = int'(sample);
      c = int'(lerp_ctrl);
      for (int i = 0; i < 10; i++) begin
        tick();
        chk("bp_valid", int'(valid), 1);
        chk("bp_sample", int'(sample), s);
        chk("bp_rd", int'(tbl_rd), 0);
        chk("bp_phase", int'(lerp_ctrl), c);
      end
    end
    rdy = 1'b1;
    tick();
    chk("bp_release", int'(valid), 0);
    en = 1'b0;
    wait_idle();

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      step = 24'($urandom);
      rdy  = ($urandom_range(0, 3) != 0);
      en   = ($urandom_range(0, 7) != 0);
`ifdef WTL_PHASE_CLR_EN
      clr  = ($urandom_range(0, 15) == 0);
`endif
      tick();
    end
    en = 1'b0; rdy = 1'b1; clr = 1'b0;
    wait_idle();

    // Table wrap: idx 0xFF pairs with entry 0
    do_reset();
    mem[8'h00] = 8'h01; mem[8'hFF] = 8'h7F;
    step = 24'hFF8000; rdy = 1'b1; en = 1'b1;
    wait_valid();
    tick();
    chk("wrap_rd0", int'(tbl_rd), 1);
    chk("wrap_addr0", int'(tbl_addr), 32'hFF);
    tick();
    chk("wrap_rd1", int'(tbl_rd), 1);
    chk("wrap_addr1", int'(tbl_addr), 0);
    wait_valid();
    chk("wrap_sample", int'(sample) & 32'h00FF_FFFF, 32'h400000);
    en = 1'b0;
    tick();
    wait_idle();

    // Phase accumulator wrap: 0xFFFF00 + 0x200 -> 0x000100
    do_reset();
    step = 24'hFFFF00; rdy = 1'b1; en = 1'b1;
    wait_valid();
    tick();
    step = 24'h000200;
    wait_valid();
    tick();
    chk("phwrap_addr", int'(tbl_addr), 0);
    chk("phwrap_ctrl", int'(lerp_ctrl), 32'h0100);
    en = 1'b0;
    wait_idle();

`ifdef WTL_PHASE_CLR_EN
    // Hard sync at the handshake
    do_reset();
    step = 24'h123456; rdy = 1'b1; en = 1'b1;
    wait_valid();
    tick();
    wait_valid();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("clr_addr", int'(tbl_addr), 0);
    chk("clr_ctrl", int'(lerp_ctrl), 0);
    en = 1'b0;
    wait_idle();
`endif

    // Enable dropped in RD_HI: in-flight sample still delivered
    step = 24'($urandom); rdy = 1'b1; en = 1'b1;
    tick();
    tick();
    en = 1'b0;
    wait_valid();
    tick();
    chk("drop_busy", int'(busy), 0);
    chk("drop_valid", int'(valid), 0);

    // Reset asserted in WAIT_HI aborts with no output
    en = 1'b1;
    tick();
    tick();
    tick();
    chk("wait_hi_busy", int'(busy), 1);
    do_reset();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
